wave_meter: RTL and testbench
=============================

Name: wave_meter

Overview:
Sample-stream analyzer for the function generator's 8-bit waveform output. It watches the samples coming from any wave generator and detects rising midpoint crossings, using a hysteresis comparator. For each full cycle it reports the period in samples, plus the minimum, maximum and peak-to-peak amplitude. It is used on-board for self-check and display of generated waves, and in benches as a golden observer.

Parameters:
WIDTH, 8, sample width in bits
MID, 127, midpoint threshold
HYST, 4, hysteresis half-band; high threshold = MID+HYST, low threshold = MID-HYST
CNT_W, 16, period counter width

Ports:
clk  in  1  clock
rst  in  1  reset
sample_en  in  1  sample qualifier; a sample is accepted only on a clk edge with sample_en=1
sample  in  WIDTH  unsigned sample value
period  out  CNT_W  samples per last complete cycle
vmin  out  WIDTH  minimum over last complete cycle
vmax  out  WIDTH  maximum over last complete cycle
amplitude  out  WIDTH  vmax-vmin of last complete cycle
meas_valid  out  1  one-cycle pulse when new results are published
locked  out  1  at least one cycle measured since reset or last timeout
timeout  out  1  one-cycle pulse when no edge is seen within the counter range

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears all outputs to 0, the internal counter, min/max accumulators and the above flag, and sets state to ARM.
- Reset mid-cycle discards partial data; there is no publish on reset.
- Accepted sample: sample_en=1 at a clk edge. With sample_en=0, no internal state changes and all pulses are 0.
- Hysteresis flag above:
  - Set when sample >= MID+HYST.
  - Cleared when sample <= MID-HYST.
  - Otherwise holds.
- Rising edge event: an accepted sample that sets above from 0 to 1, in state SEEK or MEASURE.
- States:
  - ARM: the first accepted sample outside the dead band initializes above and never produces an event. Then go to SEEK. Dead-band samples keep the block in ARM.
  - SEEK: on a rising edge:
    - cnt <= 1
    - min_acc and max_acc <= sample
    - go to MEASURE
    - no publish
  - MEASURE, non-edge accepted sample:
    - cnt <= cnt+1
    - min_acc <= min(min_acc, sample)
    - max_acc <= max(max_acc, sample)
  - MEASURE, rising edge:
    - publish period=cnt, vmin=min_acc, vmax=max_acc, amplitude=max_acc-min_acc
    - the edge sample is excluded from the published cycle
    - then cnt <= 1 and min_acc = max_acc = sample; stay in MEASURE
- Publish timing: outputs are registered and update on the clock edge that accepts the edge sample. meas_valid=1 for exactly that following cycle. Values hold until the next publish and are not cleared on timeout.
- locked: set on each publish; cleared on timeout or reset.
- Timeout: in MEASURE, an accepted non-edge sample while cnt == 2^CNT_W-1 causes:
  - timeout pulse for one cycle
  - locked <= 0
  - go to SEEK; the above flag is retained
  - the counter never wraps
- Simultaneous edge and cnt at maximum: the edge wins, the publish happens and there is no timeout.
- Arithmetic: unsigned compares; the amplitude subtraction cannot underflow since min <= max.
- Latency: the edge sample to meas_valid is 1 clk.

Test Plan:
1. Square wave. After reset, send repeated cycles of 10x200 then 10x50, with sample_en=1 every clock.
   -> The first publish occurs at the 2nd rising edge, with period=20, vmin=50, vmax=200, amplitude=150, locked=1.
   -> A meas_valid pulse follows every 20 samples after that.
2. Triangle. Send 0,1,...,254,253,...,1 repeated.
   -> period=508, vmin=0, vmax=254, amplitude=254. The edge occurs at sample value 131.
3. Dead-band chatter. Send a high phase, then alternate 125/129 for 100 samples, then 200.
   -> There is no event during the chatter.
   -> The above flag stays 1, so 200 produces no edge. An edge requires <=123 first.
4. Initial high plus sample_en gaps. The first sample after reset is 200, followed by the square wave from scenario 1 with sample_en=1 only every 3rd clock.
   -> There is no event on the first sample.
   -> Publish values match scenario 1 (period=20); meas_valid is 1 clock wide.
5. Timeout. Run with CNT_W=8. Lock on the square wave, then hold 200 constantly.
   -> After 255 accepted samples counted from the last edge, the timeout pulse occurs and locked=0. Previous period/vmin/vmax are retained.
   -> A later 50 then 200 gives a SEEK edge with no publish; the next edge publishes.
6. Reset mid-cycle. Assert rst asynchronously (between clock edges) mid-MEASURE.
   -> All outputs read 0 immediately and the state is ARM.
   -> After release, the square wave relocks with correct values and no stale publish.

Source files
------------

// File: rtl/wave_meter.sv
// wave_meter: rising-midpoint-crossing analyzer for an unsigned sample stream.
// A hysteresis comparator tracks whether the wave is above the midpoint. Each
// rising crossing closes the current cycle and publishes its period (in
// accepted samples), minimum, maximum and peak-to-peak amplitude.
module wave_meter #(
  parameter int WIDTH = 8,
  parameter int MID   = 127,
  parameter int HYST  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] sample,
  output logic [CNT_W-1:0] period,
  output logic [WIDTH-1:0] vmin,
  output logic [WIDTH-1:0] vmax,
  output logic [WIDTH-1:0] amplitude,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int HiTh = MID + HYST;
  localparam int LoTh = MID - HYST;

  typedef enum logic [1:0] {StArm, StSeek, StMeasure} state_t;

  state_t           state_q, state_d;
  logic             above_q, above_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] vmin_q, vmin_d;
  logic [WIDTH-1:0] vmax_q, vmax_d;
  logic [WIDTH-1:0] amp_q, amp_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic is_high, is_low, above_new, rise, cnt_full;

  // Hysteresis comparator: the flag only moves outside the dead band.
  always_comb begin
    is_high   = (int'(sample) >= HiTh);
    is_low    = (int'(sample) <= LoTh);
    above_new = is_high ? 1'b1 : (is_low ? 1'b0 : above_q);
    rise      = above_new & ~above_q;
    cnt_full  = (cnt_q == {CNT_W{1'b1}});
  end

  // Next-state logic: cycle accumulation, publish and timeout handling.
  always_comb begin
    state_d   = state_q;
    above_d   = above_q;
    cnt_d     = cnt_q;
    min_d     = min_q;
    max_d     = max_q;
    period_d  = period_q;
    vmin_d    = vmin_q;
    vmax_d    = vmax_q;
    amp_d     = amp_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        StArm: begin
          // First decisive sample only initializes the flag; it is never an edge.
          if (is_high || is_low) begin
            above_d = above_new;
            state_d = StSeek;
          end
        end
        StSeek: begin
          above_d = above_new;
          if (rise) begin
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            min_d   = sample;
            max_d   = sample;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          above_d = above_new;
          if (rise) begin
            // Edge wins over a full counter; the edge sample opens the next cycle.
            period_d = cnt_q;
            vmin_d   = min_q;
            vmax_d   = max_q;
            amp_d    = max_q - min_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
            min_d    = sample;
            max_d    = sample;
          end else if (cnt_full) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = StSeek;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sample < min_q) min_d = sample;
            if (sample > max_q) max_d = sample;
          end
        end
        default: state_d = StArm;
      endcase
    end
  end

  // State and result registers; reset discards any partial cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StArm;
      above_q   <= 1'b0;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      period_q  <= '0;
      vmin_q    <= '0;
      vmax_q    <= '0;
      amp_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      above_q   <= above_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      period_q  <= period_d;
      vmin_q    <= vmin_d;
      vmax_q    <= vmax_d;
      amp_q     <= amp_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign vmin       = vmin_q;
  assign vmax       = vmax_q;
  assign amplitude  = amp_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_wave_meter.sv
// Bench for wave_meter: two instances (16-bit and 8-bit period counter) share
// one stimulus stream; a queue-based cycle model predicts every output.
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sample_en = 1'b0;
  logic [7:0]  sample = 8'd0;

  logic [15:0] period0;
  logic [7:0]  vmin0, vmax0, amp0;
  logic        mv0, lock0, to0;
  logic [7:0]  period1;
  logic [7:0]  vmin1, vmax1, amp1;
  logic        mv1, lock1, to1;

  wave_meter #(.WIDTH(8), .MID(127), .HYST(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample),
    .period(period0), .vmin(vmin0), .vmax(vmax0), .amplitude(amp0),
    .meas_valid(mv0), .locked(lock0), .timeout(to0)
  );

  wave_meter #(.WIDTH(8), .MID(127), .HYST(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample),
    .period(period1), .vmin(vmin1), .vmax(vmax1), .amplitude(amp1),
    .meas_valid(mv1), .locked(lock1), .timeout(to1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for first decisive sample, 1 = seeking an edge,
  // 2 = collecting the samples of the current cycle.
  int unsigned cmax [2] = '{65535, 255};
  int          ph [2];
  bit          ab [2];
  int          cyc [2][$];
  int          e_period [2], e_vmin [2], e_vmax [2], e_amp [2];
  bit          e_mv [2], e_lock [2], e_to [2];
  int          last_s;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; ab[i] = 0; cyc[i].delete();
      e_period[i] = 0; e_vmin[i] = 0; e_vmax[i] = 0; e_amp[i] = 0;
      e_mv[i] = 0; e_lock[i] = 0; e_to[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i, input int s);
    bit hi, lo, nab, rise;
    int mn, mx;
    hi = (s >= 131);
    lo = (s <= 123);
    nab = hi ? 1'b1 : (lo ? 1'b0 : ab[i]);
    rise = nab && !ab[i];
    e_mv[i] = 0;
    e_to[i] = 0;
    if (ph[i] == 0) begin
      if (hi || lo) begin ab[i] = nab; ph[i] = 1; end
    end else begin
      ab[i] = nab;
      if (rise) begin
        if (ph[i] == 2) begin
          mn = 255; mx = 0;
          foreach (cyc[i][k]) begin
            if (cyc[i][k] < mn) mn = cyc[i][k];
            if (cyc[i][k] > mx) mx = cyc[i][k];
          end
          e_period[i] = cyc[i].size();
          e_vmin[i] = mn; e_vmax[i] = mx; e_amp[i] = mx - mn;
          e_mv[i] = 1; e_lock[i] = 1;
        end
        cyc[i].delete();
        cyc[i].push_back(s);
        ph[i] = 2;
      end else if (ph[i] == 2) begin
        if (cyc[i].size() == cmax[i]) begin
          e_to[i] = 1; e_lock[i] = 0; ph[i] = 1; cyc[i].delete();
        end else begin
          cyc[i].push_back(s);
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else if (sample_en) begin
      last_s = int'(sample);
      for (int i = 0; i < 2; i++) model_step(i, int'(sample));
    end else begin
      for (int i = 0; i < 2; i++) begin e_mv[i] = 0; e_to[i] = 0; end
    end
  end

  // ---------------- compare process ----------------
  int mv_hi [2];
  int to_hi [2];
  int mv_at;

  always @(negedge clk) begin
    if (run) begin
      chk("period16", int'(period0), e_period[0]);
      chk("vmin16", int'(vmin0), e_vmin[0]);
      chk("vmax16", int'(vmax0), e_vmax[0]);
      chk("amp16", int'(amp0), e_amp[0]);
      chk("valid16", int'(mv0), int'(e_mv[0]));
      chk("locked16", int'(lock0), int'(e_lock[0]));
      chk("timeout16", int'(to0), int'(e_to[0]));
      chk("period8", int'(period1), e_period[1]);
      chk("vmin8", int'(vmin1), e_vmin[1]);
      chk("vmax8", int'(vmax1), e_vmax[1]);
      chk("amp8", int'(amp1), e_amp[1]);
      chk("valid8", int'(mv1), int'(e_mv[1]));
      chk("locked8", int'(lock1), int'(e_lock[1]));
      chk("timeout8", int'(to1), int'(e_to[1]));
      if (mv0) begin mv_hi[0]++; mv_at = last_s; end
      if (mv1) mv_hi[1]++;
      if (to0) to_hi[0]++;
      if (to1) to_hi[1]++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input bit en, input int v);
    sample_en = en;
    sample = v[7:0];
    @(posedge clk);
    #2;
    sample_en = 1'b0;
  endtask

  task automatic square(input int cycles, input int every);
    for (int c = 0; c < cycles; c++)
      for (int k = 0; k < 20; k++) begin
        send(1'b1, (k < 10) ? 200 : 50);
        for (int g = 1; g < every; g++) send(1'b0, 0);
      end
  endtask

  task automatic clear_counts();
    mv_hi = '{0, 0};
    to_hi = '{0, 0};
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_period", int'(period0), 0);
    chk("rst_vmin", int'(vmin0), 0);
    chk("rst_vmax", int'(vmax0), 0);
    chk("rst_amp", int'(amp0), 0);
    chk("rst_valid", int'(mv0), 0);
    chk("rst_locked", int'(lock0), 0);
    chk("rst_locked8", int'(lock1), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int v, dir, lo_b, hi_b, step, nz, mv_before;
    run = 1'b1;
    do_reset();

    // 1: square wave, enable every clock
    square(3, 1);
    send(1'b0, 0);
    chk("sq_publish_count", mv_hi[0], 1);
    chk("sq_period", int'(period0), 20);
    chk("sq_vmin", int'(vmin0), 50);
    chk("sq_vmax", int'(vmax0), 200);
    chk("sq_amp", int'(amp0), 150);
    chk("sq_locked", int'(lock0), 1);
    square(2, 1);
    send(1'b0, 0);
    chk("sq_publish_count2", mv_hi[0], 3);

    // 2: triangle 0..254..1
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k <= 254; k++) send(1'b1, k);
      for (int k = 253; k >= 1; k--) send(1'b1, k);
    end
    send(1'b0, 0);
    chk("tri_publish_count", mv_hi[0], 2);
    chk("tri_period", int'(period0), 508);
    chk("tri_vmin", int'(vmin0), 0);
    chk("tri_vmax", int'(vmax0), 254);
    chk("tri_amp", int'(amp0), 254);
    chk("tri_edge_value", mv_at, 131);

    // 3: dead-band chatter after a high phase
    do_reset();
    for (int k = 0; k < 5; k++) send(1'b1, 50);
    for (int k = 0; k < 5; k++) send(1'b1, 200);
    for (int k = 0; k < 100; k++) send(1'b1, (k % 2 == 0) ? 125 : 129);
    for (int k = 0; k < 5; k++) send(1'b1, 200);
    send(1'b0, 0);
    chk("chatter_no_publish", mv_hi[0], 0);
    send(1'b1, 50);
    send(1'b1, 200);
    send(1'b0, 0);
    chk("chatter_publish", mv_hi[0], 1);
    chk("chatter_period", int'(period0), 111);
    chk("chatter_vmin", int'(vmin0), 50);
    chk("chatter_vmax", int'(vmax0), 200);

    // 4: initial high sample, then square wave with enable every 3rd clock
    do_reset();
    send(1'b1, 200);
    send(1'b0, 0);
    chk("gap_first_no_event", mv_hi[0], 0);
    square(3, 3);
    send(1'b1, 200);
    send(1'b0, 0);
    send(1'b0, 0);
    chk("gap_pulse_cycles", mv_hi[0], 2);
    chk("gap_period", int'(period0), 20);
    chk("gap_vmin", int'(vmin0), 50);
    chk("gap_vmax", int'(vmax0), 200);

    // 5: timeout on the 8-bit counter instance
    do_reset();
    square(3, 1);
    for (int k = 0; k < 255; k++) send(1'b1, 200);
    send(1'b0, 0);
    chk("to_not_yet", to_hi[1], 0);
    chk("to_locked_before", int'(lock1), 1);
    send(1'b1, 200);
    @(negedge clk);
    #1;
    chk("to_pulse", int'(to1), 1);
    chk("to_locked_after", int'(lock1), 0);
    chk("to_period_kept", int'(period1), 20);
    chk("to_vmin_kept", int'(vmin1), 50);
    chk("to_vmax_kept", int'(vmax1), 200);
    mv_before = mv_hi[1];
    send(1'b1, 50);
    send(1'b1, 200);
    send(1'b0, 0);
    chk("to_seek_edge_no_publish", mv_hi[1], mv_before);
    for (int k = 0; k < 9; k++) send(1'b1, 200);
    for (int k = 0; k < 10; k++) send(1'b1, 50);
    send(1'b1, 200);
    send(1'b0, 0);
    chk("to_relock_publish", mv_hi[1], mv_before + 1);
    chk("to_relock_period", int'(period1), 20);
    chk("to_relock_locked", int'(lock1), 1);
    chk("to_pulse_count", to_hi[1], 1);

    // 6: reset in the middle of a measured cycle
    do_reset();
    square(3, 1);
    for (int k = 0; k < 5; k++) send(1'b1, 200);
    do_reset();
    square(2, 1);
    send(1'b0, 0);
    chk("rr_no_stale_publish", mv_hi[0], 0);
    send(1'b1, 200);
    send(1'b0, 0);
    chk("rr_publish", mv_hi[0], 1);
    chk("rr_period", int'(period0), 20);
    chk("rr_amp", int'(amp0), 150);

    // 7: randomized waves, noise and enable gaps, one mid-run reset
    do_reset();
    v = 128; dir = 1; lo_b = 0; hi_b = 255; step = 1;
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) begin
        lo_b = int'($urandom_range(0, 100));
        hi_b = int'($urandom_range(150, 255));
        step = int'($urandom_range(1, 9));
      end
      if (k >= 3000 && k < 3400) begin
        v = int'($urandom_range(0, 255));
      end else begin
        v = v + dir * step;
        if (v >= hi_b) begin v = hi_b; dir = -1; end
        else if (v <= lo_b) begin v = lo_b; dir = 1; end
      end
      nz = v + int'($urandom_range(0, 6)) - 3;
      if (nz < 0) nz = 0;
      if (nz > 255) nz = 255;
      send($urandom_range(0, 3) != 0, nz);
      if (k == 2000) do_reset();
    end
    send(1'b0, 0);

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
